// File: rtl/multicycle_adder.sv
// ----------------------------------------------------------------------------
// multicycle_adder
//
// Purpose:
//   Multi-cycle add/subtract unit. A WIDTH-bit operand pair is processed
//   CHUNK bits per clock, least-significant chunk first. The carry between
//   chunks is held in a register, so only a CHUNK-bit adder is needed.
//   A start/busy/done handshake surrounds each operation.
//   Subtraction is done as x + ~y + 1.
//
// Parameters:
//   WIDTH  operand/result width in bits
//   CHUNK  bits added per clock; must divide WIDTH evenly (N = WIDTH/CHUNK)
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous active-high reset
//   start      in   1      operation request, only honoured while not busy
//   sub        in   1      0: z = x + y + carry_in, 1: z = x - y
//   x          in   WIDTH  operand A, captured with start
//   y          in   WIDTH  operand B, captured with start
//   carry_in   in   1      carry in for add mode, captured with start
//   busy       out  1      high while chunks are being processed
//   done       out  1      one-cycle pulse when z/carry_out/overflow update
//   z          out  WIDTH  result, held until the next completion
//   carry_out  out  1      carry out of the MSB (sub mode: 1 = no borrow)
//   overflow   out  1      signed overflow of the last operation
// ----------------------------------------------------------------------------
module multicycle_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] z,
    output logic             carry_out,
    output logic             overflow
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    // Refuse to elaborate when the operand does not split into whole chunks.
    generate
        if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_badChunk
            $error("multicycle_adder: CHUNK must divide WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } stateT;

    stateT            r_state;
    stateT            w_stateNext;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_z;
    logic             r_cout;
    logic             r_ovf;

    logic [CHUNK-1:0] w_aChunk;
    logic [CHUNK-1:0] w_bChunk;
    logic [CHUNK:0]   w_sum;
    logic [WIDTH-1:0] w_accNext;
    logic             w_msbCarryIn;
    logic             w_lastChunk;
    logic             w_accept;

    // The chunk datapath: select chunk r_idx of both operands, add it with
    // the carry register, and build the accumulator as it will look once this
    // chunk's sum is written in. The selection is done with a loop over
    // constant part-selects so every slice has a fixed position. The carry
    // into the sum's top bit is recovered as a ^ b ^ s, which on the last
    // chunk is the carry into the operand MSB needed for signed overflow.
    always_comb begin
        w_aChunk  = '0;
        w_bChunk  = '0;
        w_accNext = r_acc;
        for (int k = 0; k < N; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_aChunk = r_a[k*CHUNK +: CHUNK];
                w_bChunk = r_b[k*CHUNK +: CHUNK];
            end
        end
        w_sum = {1'b0, w_aChunk} + {1'b0, w_bChunk} + {{CHUNK{1'b0}}, r_carry};
        for (int k = 0; k < N; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_accNext[k*CHUNK +: CHUNK] = w_sum[CHUNK-1:0];
            end
        end
        w_msbCarryIn = w_aChunk[CHUNK-1] ^ w_bChunk[CHUNK-1] ^ w_sum[CHUNK-1];
        w_lastChunk  = (r_idx == LAST_IDX);
    end

    // A new request is taken from IDLE and also from DONE, which is what
    // allows back-to-back operations without an idle gap.
    assign w_accept = (r_state != RUN) && start;

    // Next-state logic for the IDLE -> RUN -> DONE sequence.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_stateNext = RUN;
                end
            end
            RUN: begin
                if (w_lastChunk) begin
                    w_stateNext = DONE;
                end
            end
            DONE: begin
                w_stateNext = start ? RUN : IDLE;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // State register and datapath registers. On acceptance the operands are
    // captured, with B inverted and the carry forced to 1 for subtraction.
    // Each RUN cycle folds one chunk in; the last one also publishes the
    // result and flags, so z only moves at completion or reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_acc   <= '0;
            r_z     <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            if (w_accept) begin
                r_a     <= x;
                r_b     <= sub ? ~y : y;
                r_carry <= sub ? 1'b1 : carry_in;
                r_idx   <= '0;
            end else if (r_state == RUN) begin
                r_acc   <= w_accNext;
                r_carry <= w_sum[CHUNK];
                r_idx   <= w_lastChunk ? '0 : r_idx + 1'b1;
                if (w_lastChunk) begin
                    r_z    <= w_accNext;
                    r_cout <= w_sum[CHUNK];
                    r_ovf  <= w_msbCarryIn ^ w_sum[CHUNK];
                end
            end
        end
    end

    // Handshake outputs come straight from the state register, so done is
    // high for exactly the single DONE cycle.
    assign busy      = (r_state == RUN);
    assign done      = (r_state == DONE);
    assign z         = r_z;
    assign carry_out = r_cout;
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_multicycle_adder.sv
// ----------------------------------------------------------------------------
// tb_multicycle_adder
//
// Purpose:
//   Self-checking bench for multicycle_adder. Four instances with WIDTH=8 and
//   CHUNK = 1, 2, 4, 8 share the same inputs; the CHUNK=2 instance (index 1)
//   is the main device for the directed tests, and all four are compared
//   against a behavioural model on random operations.
// ----------------------------------------------------------------------------
module tb_multicycle_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       sub;
    logic [7:0] x;
    logic [7:0] y;
    logic       carry_in;

    logic [3:0] busyV;
    logic [3:0] doneV;
    logic [3:0] coutV;
    logic [3:0] ovfV;
    logic [7:0] zV [4];

    logic       busy;
    logic       done;
    logic [7:0] z;
    logic       carry_out;
    logic       overflow;

    int totalChecks = 0;
    int badChecks   = 0;

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // One instance per chunk size; index g has CHUNK = 2**g.
    for (genvar g = 0; g < 4; g++) begin : g_dut
        multicycle_adder #(
            .WIDTH (8),
            .CHUNK (1 << g)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start),
            .sub       (sub),
            .x         (x),
            .y         (y),
            .carry_in  (carry_in),
            .busy      (busyV[g]),
            .done      (doneV[g]),
            .z         (zV[g]),
            .carry_out (coutV[g]),
            .overflow  (ovfV[g])
        );
    end

    // Main device under test is the CHUNK=2 instance.
    assign busy      = busyV[1];
    assign done      = doneV[1];
    assign z         = zV[1];
    assign carry_out = coutV[1];
    assign overflow  = ovfV[1];

    // Every comparison goes through here.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        totalChecks++;
        if (actual !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request for a single edge (the start edge).
    task automatic applyStimulus(input logic s, input logic [7:0] a,
                                 input logic [7:0] b, input logic c);
        sub      = s;
        x        = a;
        y        = b;
        carry_in = c;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // Wait (bounded) for done on the main device, counting edges and busy cycles.
    task automatic waitDone(output int lat, output int busyCnt);
        lat     = 0;
        busyCnt = 0;
        while (!done && lat < 20) begin
            if (busy) busyCnt++;
            tick();
            lat++;
        end
    endtask

    // Full directed operation on the main device with all result checks.
    task automatic runOp(input string tag, input logic s, input logic [7:0] a,
                         input logic [7:0] b, input logic c, input logic [7:0] expZ,
                         input logic expCout, input logic expOvf);
        int lat;
        int busyCnt;
        applyStimulus(s, a, b, c);
        waitDone(lat, busyCnt);
        checkOutput({tag, " latency"}, lat, 4);
        checkOutput({tag, " busyCycles"}, busyCnt, 4);
        checkOutput({tag, " done"}, done, 1);
        checkOutput({tag, " busyAtDone"}, busy, 0);
        checkOutput({tag, " z"}, z, expZ);
        checkOutput({tag, " carry_out"}, carry_out, expCout);
        checkOutput({tag, " overflow"}, overflow, expOvf);
        tick();
        checkOutput({tag, " donePulse"}, done, 0);
    endtask

    initial begin
        int lat;
        int busyCnt;
        int gap;
        int doneCnt;
        int zChanges;
        logic [7:0] zHeld;

        rst      = 1'b1;
        start    = 1'b0;
        sub      = 1'b0;
        x        = '0;
        y        = '0;
        carry_in = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        checkOutput("reset busy", busy, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset z", z, 0);
        checkOutput("reset carry_out", carry_out, 0);
        checkOutput("reset overflow", overflow, 0);

        // Directed vectors with hand-computed results.
        runOp("add5A3C", 1'b0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
        runOp("addFF01c1", 1'b0, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0);
        runOp("sub1020", 1'b1, 8'h10, 8'h20, 1'b0, 8'hF0, 1'b0, 1'b0);
        runOp("sub8001", 1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1);
        runOp("sub1020cinIgnored", 1'b1, 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);

        // Start pulsed mid-run with different operands must be ignored.
        applyStimulus(1'b0, 8'h5A, 8'h3C, 1'b0);
        x     = 8'hFF;
        y     = 8'hFF;
        sub   = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        waitDone(lat, busyCnt);
        checkOutput("ignoreStart latency", lat + 1, 4);
        checkOutput("ignoreStart z", z, 8'h96);
        checkOutput("ignoreStart carry_out", carry_out, 0);
        checkOutput("ignoreStart overflow", overflow, 1);

        // Start during the DONE cycle: back-to-back, next done 5 cycles later.
        sub      = 1'b1;
        x        = 8'h10;
        y        = 8'h20;
        carry_in = 1'b0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("b2b zHeld", z, 8'h96);
        gap = 1;
        while (!done && gap < 20) begin
            tick();
            gap++;
        end
        checkOutput("b2b gap", gap, 5);
        checkOutput("b2b z", z, 8'hF0);
        checkOutput("b2b carry_out", carry_out, 0);
        tick();

        // Reset while chunk 2 is about to be processed aborts the operation.
        applyStimulus(1'b0, 8'h5A, 8'h3C, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("abort busy", busy, 0);
        checkOutput("abort done", done, 0);
        checkOutput("abort z", z, 0);
        checkOutput("abort carry_out", carry_out, 0);
        checkOutput("abort overflow", overflow, 0);
        doneCnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done) doneCnt++;
        end
        checkOutput("abort noDone", doneCnt, 0);
        runOp("afterAbort", 1'b0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);

        // Hold behaviour: done once, z stable over 20 idle cycles.
        applyStimulus(1'b1, 8'h80, 8'h01, 1'b0);
        waitDone(lat, busyCnt);
        doneCnt  = done ? 1 : 0;
        zHeld    = z;
        zChanges = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) doneCnt++;
            if (z !== zHeld) zChanges++;
        end
        checkOutput("hold doneCount", doneCnt, 1);
        checkOutput("hold zChanges", zChanges, 0);
        checkOutput("hold z", z, 8'h7F);

        // Random operations on all four chunk sizes versus a behavioural model.
        for (int n = 0; n < 1000; n++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            logic       rs;
            logic       rc;
            logic [7:0] bEff;
            logic [8:0] full;
            logic       expOvf;
            int         latG [4];
            logic [7:0] zCap [4];
            logic [3:0] coutCap;
            logic [3:0] ovfCap;

            ra   = 8'($urandom_range(0, 255));
            rb   = 8'($urandom_range(0, 255));
            rs   = 1'($urandom_range(0, 1));
            rc   = 1'($urandom_range(0, 1));
            bEff = rs ? ~rb : rb;
            full = rs ? ({1'b0, ra} + {1'b0, bEff} + 9'd1)
                      : ({1'b0, ra} + {1'b0, rb} + {8'd0, rc});
            expOvf = (ra[7] == bEff[7]) && (full[7] != ra[7]);

            for (int g = 0; g < 4; g++) begin
                latG[g] = 99;
                zCap[g] = '0;
            end
            coutCap = '0;
            ovfCap  = '0;

            applyStimulus(rs, ra, rb, rc);
            for (int t = 1; t <= 10; t++) begin
                tick();
                for (int g = 0; g < 4; g++) begin
                    if (doneV[g] && latG[g] == 99) begin
                        latG[g]    = t;
                        zCap[g]    = zV[g];
                        coutCap[g] = coutV[g];
                        ovfCap[g]  = ovfV[g];
                    end
                end
            end
            for (int g = 0; g < 4; g++) begin
                checkOutput($sformatf("rnd%0d chunk%0d latency", n, 1 << g), latG[g], 8 >> g);
                checkOutput($sformatf("rnd%0d chunk%0d z", n, 1 << g), zCap[g], full[7:0]);
                checkOutput($sformatf("rnd%0d chunk%0d carry_out", n, 1 << g), coutCap[g], full[8]);
                checkOutput($sformatf("rnd%0d chunk%0d overflow", n, 1 << g), ovfCap[g], expOvf);
            end
        end

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
